tag_free_list: RTL and testbench

Maintains a pool of 64 allocation tags as a free-bit mask and hands out one tag per cycle through a registered valid/ready output. Tags are returned through a single free port. The block sits directly upstream of the team's 64-bit find-index encoder: it owns the mask that the encoder scans, and it registers the encoder's result into the grant stage. Consumers are the rename/scheduling front-end, which allocate tags, and the retire logic, which frees them.

---
 rtl/tag_free_list.sv | 116 +++++++++++
 tb/tb_tag_free_list.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/tag_free_list.sv
// rtl/tag_free_list.sv - 64-entry tag free list with registered lowest-free-tag grant stage

module tag_free_list_ffs #(
    parameter int ALLOC = 1
) (
    input  logic [63:0] vec,
    output logic [5:0]  idx,
    output logic        found
);

    // ALLOC=1 searches for the lowest set bit, ALLOC=0 for the lowest clear bit.
    always_comb begin
        idx   = '0;
        found = (ALLOC != 0) ? (|vec) : (~&vec);
        for (int i = 63; i >= 0; i--) begin
            if (vec[i] == (ALLOC != 0)) begin
                idx = 6'(i);
            end
        end
    end

endmodule

module tag_free_list #(
    parameter int LOW_WM = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       alloc_vld,
    output logic [5:0] alloc_idx,
    input  logic       alloc_rdy,
    input  logic       free_vld,
    input  logic [5:0] free_idx,
    input  logic       flush,
    output logic [6:0] free_cnt,
    output logic       low_wm,
    output logic       err
);

    localparam logic [6:0] WM = 7'(LOW_WM);

    logic [63:0] mask;
    logic [63:0] mask_nxt;
    logic        out_v;
    logic [5:0]  out_idx;
    logic [6:0]  cnt;
    logic [6:0]  cnt_nxt;
    logic        lw;
    logic        err_q;
    logic [5:0]  sel;
    logic        any;
    logic        reload;
    logic        dbl_free;
    logic        rsv_free;
    logic        inc;

    tag_free_list_ffs #(.ALLOC(1)) u_ffs (
        .vec   (mask),
        .idx   (sel),
        .found (any)
    );

    assign reload   = any && (!out_v || alloc_rdy);
    assign dbl_free = free_vld && mask[free_idx];
    assign rsv_free = free_vld && out_v && (out_idx == free_idx);
    assign inc      = free_vld && !mask[free_idx];

    // Selection sees the pre-free mask, so a returned tag only becomes eligible next cycle.
    always_comb begin
        mask_nxt = mask;
        if (free_vld) begin
            mask_nxt[free_idx] = 1'b1;
        end
        if (reload) begin
            mask_nxt[sel] = 1'b0;
        end
    end

    assign cnt_nxt = cnt + {6'b0, inc} - {6'b0, reload};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask    <= '1;
            out_v   <= 1'b0;
            out_idx <= '0;
            cnt     <= 7'd64;
            lw      <= 1'b0;
            err_q   <= 1'b0;
        end else if (flush) begin
            mask  <= '1;
            out_v <= 1'b0;
            cnt   <= 7'd64;
            lw    <= (7'd64 <= WM);
        end else begin
            mask <= mask_nxt;
            cnt  <= cnt_nxt;
            lw   <= (cnt_nxt <= WM);
            if (reload) begin
                out_v   <= 1'b1;
                out_idx <= sel;
            end else if (alloc_rdy) begin
                out_v <= 1'b0;
            end
            if (dbl_free || rsv_free) begin
                err_q <= 1'b1;
            end
        end
    end

    assign alloc_vld = out_v;
    assign alloc_idx = out_idx;
    assign free_cnt  = cnt;
    assign low_wm    = lw;
    assign err       = err_q;

endmodule

// File: tb/tb_tag_free_list.sv
// tb/tb_tag_free_list.sv - randomized self-checking bench for tag_free_list against a tag-pool model

module tb_tag_free_list;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alloc_vld;
    logic [5:0] alloc_idx;
    logic       alloc_rdy;
    logic       free_vld;
    logic [5:0] free_idx;
    logic       flush;
    logic [6:0] free_cnt;
    logic       low_wm;
    logic       err;

    always #5 clk = ~clk;

    tag_free_list #(.LOW_WM(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc_vld (alloc_vld),
        .alloc_idx (alloc_idx),
        .alloc_rdy (alloc_rdy),
        .free_vld  (free_vld),
        .free_idx  (free_idx),
        .flush     (flush),
        .free_cnt  (free_cnt),
        .low_wm    (low_wm),
        .err       (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Model: pool as a set of free flags, the offered tag, and the list of tags held by consumers.
    bit free_set [64];
    bit m_ov;
    int m_oi;
    bit m_err;
    int held [$];

    function automatic int m_lowest();
        for (int i = 0; i < 64; i++) if (free_set[i]) return i;
        return -1;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < 64; i++) if (free_set[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) free_set[i] = 1'b1;
        m_ov = 1'b0;
        m_oi = 0;
        m_err = 1'b0;
        held.delete();
    endtask

    task automatic model_step(input bit rdy, input bit fv, input int fi, input bit fl);
        int pick;
        if (fl) begin
            for (int i = 0; i < 64; i++) free_set[i] = 1'b1;
            m_ov = 1'b0;
            held.delete();
            return;
        end
        pick = m_lowest();
        if (m_ov && rdy) held.push_back(m_oi);
        if (fv) begin
            if (free_set[fi] || (m_ov && m_oi == fi)) m_err = 1'b1;
            free_set[fi] = 1'b1;
            for (int j = 0; j < held.size(); j++) begin
                if (held[j] == fi) begin
                    held.delete(j);
                    break;
                end
            end
        end
        if (pick >= 0 && (!m_ov || rdy)) begin
            free_set[pick] = 1'b0;
            m_ov = 1'b1;
            m_oi = pick;
        end else if (rdy) begin
            m_ov = 1'b0;
        end
    endtask

    task automatic compare(input string w);
        int c;
        c = m_count();
        check({w, "_vld"}, alloc_vld, m_ov);
        if (m_ov) check({w, "_idx"}, alloc_idx, m_oi);
        check({w, "_cnt"}, free_cnt, c);
        check({w, "_lowwm"}, low_wm, (c <= 4));
        check({w, "_err"}, err, m_err);
    endtask

    task automatic step(input bit rdy, input bit fv, input int fi, input bit fl, input string w);
        alloc_rdy = rdy;
        free_vld  = fv;
        free_idx  = 6'(fi);
        flush     = fl;
        @(posedge clk);
        model_step(rdy, fv, fi, fl);
        #1;
        compare(w);
    endtask

    task automatic do_reset();
        alloc_rdy = 1'b0;
        free_vld  = 1'b0;
        free_idx  = '0;
        flush     = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_vld", alloc_vld, 0);
        check("rst_idx", alloc_idx, 0);
        check("rst_cnt", free_cnt, 64);
        check("rst_lowwm", low_wm, 0);
        check("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_n     = 1'b1;
        alloc_rdy = 1'b0;
        free_vld  = 1'b0;
        free_idx  = '0;
        flush     = 1'b0;
        #3;
        do_reset();

        // Drain the whole pool in order.
        step(1, 0, 0, 0, "first");
        check("first_idx", alloc_idx, 0);
        check("first_cnt", free_cnt, 63);
        for (int k = 0; k < 64; k++) begin
            check("grant_order", alloc_idx, k);
            step(1, 0, 0, 0, "drain");
        end
        check("drained_vld", alloc_vld, 0);
        check("drained_cnt", free_cnt, 0);
        check("drained_lowwm", low_wm, 1);

        // Free-to-grant latency from an empty pool.
        step(1, 1, 37, 0, "free37");
        check("free37_cnt", free_cnt, 1);
        check("free37_vld", alloc_vld, 0);
        step(0, 0, 0, 0, "regrant37");
        check("regrant37_idx", alloc_idx, 37);
        check("regrant37_cnt", free_cnt, 0);

        // Backpressure holds the offered tag.
        do_reset();
        for (int k = 0; k < 5; k++) step(0, 0, 0, 0, "bp");
        check("bp_idx", alloc_idx, 0);
        step(1, 0, 0, 0, "bp_go");
        check("bp_next_idx", alloc_idx, 1);

        // Free in the same cycle as a grant.
        do_reset();
        for (int k = 0; k < 11; k++) step(1, 0, 0, 0, "pre_sim");
        check("sim_pre_idx", alloc_idx, 10);
        check("sim_pre_cnt", free_cnt, 53);
        step(1, 1, 3, 0, "sim");
        check("sim_idx", alloc_idx, 11);
        check("sim_cnt", free_cnt, 53);
        step(1, 0, 0, 0, "sim_after");
        check("sim_after_idx", alloc_idx, 3);

        // Double free and free of the reserved tag.
        do_reset();
        step(0, 0, 0, 0, "dbl_pre");
        step(0, 1, 50, 0, "dbl");
        check("dbl_err", err, 1);
        check("dbl_cnt", free_cnt, 63);
        do_reset();
        step(0, 0, 0, 0, "rsv_pre");
        step(0, 1, 0, 0, "rsv");
        check("rsv_err", err, 1);
        check("rsv_vld", alloc_vld, 1);

        // Flush beats a handshake and a free in the same cycle.
        do_reset();
        for (int k = 0; k < 4; k++) step(1, 0, 0, 0, "fl_pre");
        step(1, 1, 1, 1, "flush");
        check("flush_cnt", free_cnt, 64);
        check("flush_vld", alloc_vld, 0);
        check("flush_err", err, 0);
        step(0, 0, 0, 0, "flush_after");
        check("flush_after_idx", alloc_idx, 0);
        check("flush_after_vld", alloc_vld, 1);

        // Random traffic, with an asynchronous reset in the middle.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit rdy;
            bit fv;
            bit fl;
            int fi;
            int r;
            if (i == 1500) begin
                #2;
                do_reset();
            end
            rdy = ($urandom_range(0, 3) != 0);
            fl  = ($urandom_range(0, 199) == 0);
            fv  = 1'b0;
            fi  = 0;
            r   = $urandom_range(0, 9);
            if (held.size() > 0 && r < 4) begin
                fi = held[$urandom_range(0, held.size() - 1)];
                fv = 1'b1;
            end else if (r == 9 && $urandom_range(0, 15) == 0) begin
                fi = $urandom_range(0, 63);
                fv = 1'b1;
            end
            step(rdy, fv, fi, fl, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
